// File: rtl/priv_1_12_hpm_counters_if.sv
// priv_1_12_hpm_counters_if: CSR access, event strobes and overflow interrupt of the machine counter file
interface priv_1_12_hpm_counters_if #(parameter int NUM_EVENTS = 16) ();
  logic [11:0]           csr_addr;
  logic                  csr_wen;
  logic [31:0]           csr_wdata;
  logic [31:0]           csr_rdata;
  logic                  csr_hit;
  logic [NUM_EVENTS-1:0] events;
  logic                  instret_inc;
  logic                  overflow_irq;
  modport master (output csr_addr, csr_wen, csr_wdata, events, instret_inc,
                  input  csr_rdata, csr_hit, overflow_irq);
  modport slave  (input  csr_addr, csr_wen, csr_wdata, events, instret_inc,
                  output csr_rdata, csr_hit, overflow_irq);
endinterface

// File: rtl/priv_1_12_hpm_counters.sv
// priv_1_12_hpm_counters: mcycle/minstret/mhpmcounterN/mhpmeventN/mcountinhibit counter file.
// Optional sticky overflow bits and interrupt under `define HPM_OVERFLOW_IRQ_EN.
module priv_1_12_hpm_counters #(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_EVENTS    = 16
) (
  input logic CLK,
  input logic nRST,
  priv_1_12_hpm_counters_if.slave bus
);
  localparam logic [63:0] HMASK = {64{1'b1}} >> (64 - COUNTER_WIDTH);

  function automatic logic [31:0] impl_mask();
    logic [31:0] m;
    m = 32'h5;
    for (int i = 3; i < 3 + NUM_COUNTERS; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] cmask(int i);
    return i < 3 ? {64{1'b1}} : HMASK;
  endfunction

  localparam logic [31:0] IMPL = impl_mask();

  logic [63:0]  cnt_q [32];
  logic [63:0]  cnt_d [32];
  logic [7:0]   sel_q [32];
  logic [7:0]   sel_d [32];
  logic [31:0]  inh_q, inh_d, of_q;
  logic [31:0]  inc, lo_wr, hi_wr, ev_wr;
  logic [255:0] ev_ext;
  logic [4:0]   idx;

  assign idx    = bus.csr_addr[4:0];
  // selector value s picks events[s-1]; 0 and out-of-range selectors land on zero padding
  assign ev_ext = 256'({bus.events, 1'b0});

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      lo_wr[i] = bus.csr_wen && IMPL[i] && bus.csr_addr == 12'hB00 + 12'(i);
      hi_wr[i] = bus.csr_wen && IMPL[i] && bus.csr_addr == 12'hB80 + 12'(i);
      ev_wr[i] = bus.csr_wen && IMPL[i] && i >= 3 && bus.csr_addr == 12'h320 + 12'(i);
      inc[i]   = IMPL[i] && !inh_q[i] && (i == 0 ? 1'b1 : i == 2 ? bus.instret_inc : i >= 3 && ev_ext[sel_q[i]]);
    end
  end

  // a high-half write keeps the low-half increment but drops its carry
  always_comb begin
    inh_d = (bus.csr_wen && bus.csr_addr == 12'h320) ? bus.csr_wdata & IMPL : inh_q;
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = lo_wr[i] ? {cnt_q[i][63:32], bus.csr_wdata} & cmask(i)
               : hi_wr[i] ? {bus.csr_wdata, cnt_q[i][31:0] + 32'(inc[i])} & cmask(i)
               : inc[i]   ? (cnt_q[i] + 64'd1) & cmask(i)
               : cnt_q[i];
      sel_d[i] = ev_wr[i] ? bus.csr_wdata[7:0] : sel_q[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      inh_q <= '0;
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
        sel_q[i] <= '0;
      end
    end else begin
      inh_q <= inh_d;
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
        sel_q[i] <= sel_d[i];
      end
    end
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  logic [31:0] wrap, of_d;
  logic        irq_q;

  always_comb begin
    for (int i = 0; i < 32; i++)
      wrap[i] = i >= 3 && inc[i] && !lo_wr[i] && !hi_wr[i] && cnt_q[i] == HMASK;
    of_d = (ev_wr & {32{bus.csr_wdata[31]}}) | (~ev_wr & (of_q | wrap));
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      of_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      of_q  <= of_d;
      irq_q <= |of_q;
    end
  end

  assign bus.overflow_irq = irq_q;
`else
  assign of_q             = '0;
  assign bus.overflow_irq = 1'b0;
`endif

  // unimplemented slots never leave reset, so they read back as zero
  always_comb begin
    bus.csr_hit   = 1'b0;
    bus.csr_rdata = '0;
    if (bus.csr_addr[11:5] == 7'h58) begin
      bus.csr_hit   = idx != 5'd1;
      bus.csr_rdata = cnt_q[idx][31:0];
    end else if (bus.csr_addr[11:5] == 7'h5C) begin
      bus.csr_hit   = idx != 5'd1;
      bus.csr_rdata = cnt_q[idx][63:32];
    end else if (bus.csr_addr[11:5] == 7'h19) begin
      bus.csr_hit   = idx == 5'd0 || idx >= 5'd3;
      bus.csr_rdata = idx == 5'd0 ? inh_q : idx >= 5'd3 ? {of_q[idx], 23'd0, sel_q[idx]} : '0;
    end
  end
endmodule
